ls_unit: RTL

Load/store execution unit on the memory side of the load/store buffer. It accepts one memory operation at a time from the buffer and drives the memory controller through a request/done handshake. For loads, it sign- or zero-extends the returned data and broadcasts the value on the LS CDB. A misbranch squashes an in-flight load, but the memory transaction is always drained before a new one is accepted.

---
 rtl/ls_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ls_unit.sv
// Load/store execution unit: issues one memory operation at a time to the
// memory controller and broadcasts extended load results on the LS CDB.
module ls_unit #(
    parameter int OP_W  = 6,
    parameter int ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             misbranch_flag,
    input  logic             enable_from_lsb,
    input  logic [OP_W-1:0]  openum_from_lsb,
    input  logic [31:0]      addr_from_lsb,
    input  logic [31:0]      data_from_lsb,
    input  logic [ROB_W-1:0] rob_id_from_lsb,
    output logic             busy_to_lsb,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [2:0]       mem_size,
    output logic [31:0]      mem_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic [31:0]      cdb_result
);

    // Loads occupy the low end of the encoding so a single compare identifies them.
    localparam logic [OP_W-1:0] OPENUM_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] OPENUM_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OPENUM_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OPENUM_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] OPENUM_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] OPENUM_SB  = OP_W'(6);
    localparam logic [OP_W-1:0] OPENUM_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] OPENUM_SW  = OP_W'(8);
    localparam logic [ROB_W-1:0] ZERO_ROB  = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ABORT
    } state_t;

    state_t           state_q;
    logic [OP_W-1:0]  op_q;
    logic [ROB_W-1:0] rob_id_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [2:0]       mem_size_q;
    logic [31:0]      mem_wdata_q;
    logic             cdb_valid_q;
    logic [ROB_W-1:0] cdb_rob_id_q;
    logic [31:0]      cdb_result_q;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op <= OPENUM_LHU;
    endfunction

    function automatic logic [2:0] size_of(input logic [OP_W-1:0] op);
        case (op)
            OPENUM_LB, OPENUM_LBU, OPENUM_SB: size_of = 3'd1;
            OPENUM_LH, OPENUM_LHU, OPENUM_SH: size_of = 3'd2;
            OPENUM_LW, OPENUM_SW:             size_of = 3'd4;
            default:                          size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] mask_data(input logic [2:0] size, input logic [31:0] d);
        case (size)
            3'd1:    mask_data = {24'd0, d[7:0]};
            3'd2:    mask_data = {16'd0, d[15:0]};
            default: mask_data = d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [OP_W-1:0] op, input logic [31:0] d);
        case (op)
            OPENUM_LB:  extend = {{24{d[7]}}, d[7:0]};
            OPENUM_LBU: extend = {24'd0, d[7:0]};
            OPENUM_LH:  extend = {{16{d[15]}}, d[15:0]};
            OPENUM_LHU: extend = {16'd0, d[15:0]};
            default:    extend = d;
        endcase
    endfunction

    // state | meaning
    // IDLE  | no transaction in flight
    // BUSY  | transaction in flight, result wanted
    // ABORT | load squashed, draining memory, result discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            rob_id_q     <= ZERO_ROB;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_size_q   <= '0;
            mem_wdata_q  <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= ZERO_ROB;
            cdb_result_q <= '0;
        end else if (rdy) begin
            cdb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable_from_lsb && !misbranch_flag) begin
                        state_q     <= S_BUSY;
                        op_q        <= openum_from_lsb;
                        rob_id_q    <= rob_id_from_lsb;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= !is_load(openum_from_lsb);
                        mem_addr_q  <= addr_from_lsb;
                        mem_size_q  <= size_of(openum_from_lsb);
                        mem_wdata_q <= mask_data(size_of(openum_from_lsb), data_from_lsb);
                    end
                end
                S_BUSY: begin
                    if (mem_done) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        if (is_load(op_q) && !misbranch_flag) begin
                            cdb_valid_q  <= 1'b1;
                            cdb_rob_id_q <= rob_id_q;
                            cdb_result_q <= extend(op_q, mem_rdata);
                        end
                    end else if (misbranch_flag && is_load(op_q)) begin
                        state_q <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    if (mem_done) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_to_lsb = (state_q != S_IDLE) || enable_from_lsb;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_size    = mem_size_q;
    assign mem_wdata   = mem_wdata_q;
    assign cdb_valid   = cdb_valid_q;
    assign cdb_rob_id  = cdb_rob_id_q;
    assign cdb_result  = cdb_result_q;

endmodule
